issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_pkg.sv | 51 +++++
 rtl/issue_scoreboard.sv | 53 +++++
 rtl/issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared decode helpers and state type for the in-order bundle issue controller.
// Optional stall counter in issue_ctrl is enabled by defining ISSUE_PERF_EN.
package issue_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] ins);
        return ins[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ins);
        return ins[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] ins);
        return ins[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] ins);
        return ins[24:20];
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ins);
        logic [6:0] op;
        op = opcode_of(ins);
        return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        logic [6:0] op;
        op = opcode_of(ins);
        return op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
    endfunction

    function automatic logic writes_rd(input logic [31:0] ins);
        logic [6:0] op;
        op = opcode_of(ins);
        return !(op == OPC_STORE || op == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register writeback countdown; reports registers whose result
// cannot yet be consumed by an instruction issuing this cycle.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int EX_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_LANES-1:0]   set_valid_i,
    input  logic [NUM_LANES*5-1:0] set_idx_i,
    output logic [31:0]            busy_o
);

    logic [2:0]  r_cnt [32];
    logic [31:0] w_set;

    always_comb begin
        w_set = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (set_valid_i[l]) begin
                w_set[set_idx_i[l*5 +: 5]] = 1'b1;
            end
        end
        w_set[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (w_set[r]) begin
                    r_cnt[r] <= 3'(EX_LAT);
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 3'd1;
                end
            end
        end
    end

    // A count of 1 means the result lands this cycle and reaches a consumer
    // issuing now, so only larger counts block.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            busy_o[r] = r_cnt[r] > 3'd1;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Holds one fetch bundle and issues its longest hazard-free in-order prefix.
// Define ISSUE_PERF_EN to add the stall_cnt_o performance counter.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int EX_LAT     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bundle_valid_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] bundle_i,
    output logic                            bundle_ready_o,
    input  logic                            flush_i,
    output logic [NUM_LANES-1:0]            issue_valid_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0] issue_instr_o,
    output logic                            stall_o
`ifdef ISSUE_PERF_EN
    ,
    output logic [31:0]                     stall_cnt_o
`endif
);

    localparam int IW = (DATA_WIDTH < 32) ? DATA_WIDTH : 32;

    state_e                          r_state;
    logic [NUM_LANES-1:0]            r_mask;
    logic [NUM_LANES*DATA_WIDTH-1:0] r_buf;

    logic [31:0]            w_ins [NUM_LANES];
    logic [31:0]            w_busy;
    logic [31:0]            w_claim;
    logic                   w_stop;
    logic                   w_haz;
    logic [NUM_LANES-1:0]   w_issue;
    logic [NUM_LANES-1:0]   w_set_vld;
    logic [NUM_LANES*5-1:0] w_set_idx;
    logic [NUM_LANES-1:0]   w_left;
    logic                   w_accept;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_ins[i] = '0;
            w_ins[i][IW-1:0] = r_buf[i*DATA_WIDTH +: IW];
        end
    end

    // w_claim tracks destinations taken by older lanes issuing this cycle.
    always_comb begin
        w_issue = '0;
        w_claim = '0;
        w_stop  = 1'b0;
        w_haz   = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_mask[i] && !w_stop) begin
                w_haz = (reads_rs1(w_ins[i]) &&
                         (w_busy[rs1_of(w_ins[i])] ||
                          w_claim[rs1_of(w_ins[i])])) ||
                        (reads_rs2(w_ins[i]) &&
                         (w_busy[rs2_of(w_ins[i])] ||
                          w_claim[rs2_of(w_ins[i])])) ||
                        (writes_rd(w_ins[i]) &&
                         (w_busy[rd_of(w_ins[i])] ||
                          w_claim[rd_of(w_ins[i])]));
                if (w_haz) begin
                    w_stop = 1'b1;
                end else begin
                    w_issue[i] = 1'b1;
                    if (writes_rd(w_ins[i]) && rd_of(w_ins[i]) != 5'd0) begin
                        w_claim[rd_of(w_ins[i])] = 1'b1;
                    end
                end
            end
        end
        if (r_state != ST_HOLD || flush_i) begin
            w_issue = '0;
        end
    end

    always_comb begin
        w_set_vld = '0;
        w_set_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_set_vld[i] = w_issue[i] && writes_rd(w_ins[i]);
            w_set_idx[i*5 +: 5] = rd_of(w_ins[i]);
        end
    end

    issue_scoreboard #(
        .NUM_LANES (NUM_LANES),
        .EX_LAT    (EX_LAT)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_valid_i (w_set_vld),
        .set_idx_i   (w_set_idx),
        .busy_o      (w_busy)
    );

    always_comb begin
        if (flush_i) begin
            bundle_ready_o = 1'b0;
        end else if (r_state == ST_EMPTY) begin
            bundle_ready_o = 1'b1;
        end else begin
            bundle_ready_o = w_issue == r_mask;
        end
    end

    assign w_accept      = bundle_valid_i && bundle_ready_o;
    assign w_left        = r_mask & ~w_issue;
    assign issue_valid_o = w_issue;
    assign issue_instr_o = (r_state == ST_HOLD) ? r_buf : '0;
    assign stall_o       = (r_state == ST_HOLD) && !flush_i &&
                           (w_issue == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_mask  <= '0;
            r_buf   <= '0;
        end else if (flush_i) begin
            r_state <= ST_EMPTY;
            r_mask  <= '0;
        end else if (w_accept) begin
            r_state <= ST_HOLD;
            r_mask  <= '1;
            r_buf   <= bundle_i;
        end else if (r_state == ST_HOLD) begin
            r_mask <= w_left;
            if (w_left == '0) begin
                r_state <= ST_EMPTY;
            end
        end
    end

`ifdef ISSUE_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall_o) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: timestamp-based reference model plus
// literal expectations for the key bundle sequences.
module tb_issue_ctrl;

    localparam int NL  = 2;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           bv  = 1'b0;
    logic           fl  = 1'b0;
    logic [63:0]    bi  = '0;
    logic           brdy;
    logic [1:0]     iv;
    logic [63:0]    ii;
    logic           stl;
`ifdef ISSUE_PERF_EN
    logic [31:0]    scnt;
`endif

    issue_ctrl #(
        .NUM_LANES  (NL),
        .DATA_WIDTH (DW),
        .EX_LAT     (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bundle_valid_i (bv),
        .bundle_i       (bi),
        .bundle_ready_o (brdy),
        .flush_i        (fl),
        .issue_valid_o  (iv),
        .issue_instr_o  (ii),
        .stall_o        (stl)
`ifdef ISSUE_PERF_EN
        ,
        .stall_cnt_o    (scnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a held bundle, its pending lanes, and for each register the
    // first cycle number at which a consumer may issue.
    bit          m_hold;
    logic [31:0] m_buf [2];
    bit   [1:0]  m_pend;
    int          avail [32];
    int          cyc;
    int          m_stalls;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_r1(input logic [31:0] x);
        return !(x[6:0] inside {7'h37, 7'h17, 7'h6f});
    endfunction

    function automatic bit m_r2(input logic [31:0] x);
        return x[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit m_wr(input logic [31:0] x);
        return !(x[6:0] inside {7'h23, 7'h63}) && x[11:7] != 5'd0;
    endfunction

    function automatic bit m_busy(input int r, input bit cl [32]);
        return r != 0 && (cyc < avail[r] || cl[r]);
    endfunction

    task automatic step(input bit r, input bit v,
                        input logic [31:0] b0, input logic [31:0] b1,
                        input bit f, input bit lit,
                        input logic [1:0] liv, input bit lstl,
                        input bit lrdy);
        logic [1:0]  eiv;
        bit          erdy;
        bit          estl;
        logic [63:0] eins;
        bit          stop;
        bit          blk;
        bit          cl [32];
        logic [31:0] x;
        @(negedge clk);
        rst = r;
        bv  = v;
        bi  = {b1, b0};
        fl  = f;
        #1;
        eiv  = 2'b00;
        erdy = 1'b1;
        estl = 1'b0;
        eins = '0;
        stop = 1'b0;
        cl   = '{default: 1'b0};
        if (r && m_hold) begin
            eins = {m_buf[1], m_buf[0]};
            if (f) begin
                erdy = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (m_pend[i] && !stop) begin
                        x = m_buf[i];
                        blk = (m_r1(x) && m_busy(int'(x[19:15]), cl)) ||
                              (m_r2(x) && m_busy(int'(x[24:20]), cl)) ||
                              (m_wr(x) && m_busy(int'(x[11:7]), cl));
                        if (blk) begin
                            stop = 1'b1;
                        end else begin
                            eiv[i] = 1'b1;
                            if (m_wr(x)) cl[x[11:7]] = 1'b1;
                        end
                    end
                end
                erdy = eiv == m_pend;
                estl = eiv == 2'b00;
            end
        end else if (r && f) begin
            erdy = 1'b0;
        end
        chk("issue_valid", 64'(iv), 64'(eiv));
        chk("bundle_ready", 64'(brdy), 64'(erdy));
        chk("stall", 64'(stl), 64'(estl));
        chk("issue_instr", ii, eins);
`ifdef ISSUE_PERF_EN
        chk("stall_cnt", 64'(scnt), 64'(m_stalls));
`endif
        if (lit) begin
            chk("lit_issue_valid", 64'(iv), 64'(liv));
            chk("lit_stall", 64'(stl), 64'(lstl));
            chk("lit_ready", 64'(brdy), 64'(lrdy));
        end
        @(posedge clk);
        if (!r) begin
            m_hold   = 1'b0;
            m_pend   = 2'b00;
            m_stalls = 0;
            for (int k = 0; k < 32; k++) avail[k] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (eiv[i] && m_wr(m_buf[i])) begin
                    avail[m_buf[i][11:7]] = cyc + LAT;
                end
            end
            if (estl) m_stalls++;
            if (f) begin
                m_hold = 1'b0;
            end else if (v && erdy) begin
                m_hold   = 1'b1;
                m_buf[0] = b0;
                m_buf[1] = b1;
                m_pend   = 2'b11;
            end else if (m_hold) begin
                m_pend = m_pend & ~eiv;
                if (m_pend == 2'b00) m_hold = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
    endfunction

    initial begin
        m_hold   = 1'b0;
        m_pend   = 2'b00;
        cyc      = 0;
        m_stalls = 0;
        for (int k = 0; k < 32; k++) avail[k] = 0;

        step(0, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        step(0, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b00, 0, 1);

        // independent pair issues together
        step(1, 1, 32'h00500093, 32'h00700113, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b11, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        idle(2);

        // RAW within bundle: lane1 waits EX_LAT cycles
        step(1, 1, 32'h00500093, 32'h001081B3, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b01, 0, 0);
        step(1, 0, 0, 0, 0, 1, 2'b00, 1, 0);
        step(1, 0, 0, 0, 0, 1, 2'b10, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        idle(2);

        // x0 never creates a dependency
        step(1, 1, 32'h00000013, 32'h000001B3, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b11, 0, 1);
        idle(2);

        // back-to-back independent bundles
        step(1, 1, addi(5, 1), addi(6, 2), 0, 1, 2'b00, 0, 1);
        step(1, 1, addi(7, 3), addi(8, 4), 0, 1, 2'b11, 0, 1);
        step(1, 1, addi(9, 5), addi(10, 6), 0, 1, 2'b11, 0, 1);
        step(1, 1, addi(11, 7), addi(12, 8), 0, 1, 2'b11, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b11, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        idle(1);

        // WAW within bundle
        step(1, 1, addi(5, 1), addi(5, 2), 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b01, 0, 0);
        step(1, 0, 0, 0, 0, 1, 2'b00, 1, 0);
        step(1, 0, 0, 0, 0, 1, 2'b10, 0, 1);
        idle(2);

        // LUI does not read its rs1 field; OP-IMM does not read rs2
        step(1, 1, 32'h00500093, 32'h0000F237, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b11, 0, 1);
        idle(2);
        step(1, 1, 32'h00500093, 32'h00100313, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b11, 0, 1);
        idle(2);

        // store reads rs2 produced by lane0
        step(1, 1, 32'h00500093, 32'h00112023, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b01, 0, 0);
        step(1, 0, 0, 0, 0, 1, 2'b00, 1, 0);
        step(1, 0, 0, 0, 0, 1, 2'b10, 0, 1);
        idle(2);

        // flush during stall
        step(1, 1, 32'h00500093, 32'h001081B3, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b01, 0, 0);
        step(1, 1, addi(13, 1), addi(14, 1), 1, 1, 2'b00, 0, 0);
        step(1, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        idle(2);

        // reset during HOLD
        step(1, 1, 32'h00500093, 32'h001081B3, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b01, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        step(1, 1, 32'h001081B3, 32'h00700113, 0, 1, 2'b00, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b11, 0, 1);
        step(1, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
